sha256_padder: RTL and testbench

//  Front end of the SHA-256 source interface. Accepts a byte-granular message as 64-bit words.

---
 rtl/sha256_pkg.sv | 26 ++
 rtl/sha256_padder_if.sv | 35 +++
 rtl/sha256_padder_pad_word_gen.sv | 34 +++
 rtl/sha256_padder.sv | 165 ++++++++++++++++
 tb/tb_sha256_padder.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Purpose: shared types and constants for the SHA-256 source-side padder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha256_pkg;

    localparam int SRC_IF_DATA_W         = 64;
    localparam int SHA_IF_DATA_W         = 256;
    localparam int LEN_W                 = 61;
    localparam int SHA256_WORDS_PER_HALF = 4;
    localparam int SHA256_LEN_WORD_IDX   = 7;

    localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PAD,
        SEND
    } padder_state_e;

    // Word carrying only the 0x80 marker, used when the message ends word-aligned.
    function automatic logic [SRC_IF_DATA_W-1:0] pad_marker_word();
        return {SHA256_PAD_BYTE, {(SRC_IF_DATA_W-8){1'b0}}};
    endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Purpose: source-word and half-block handshakes of the padder in one bundle.
// Latency: n/a (wiring only).
// Backpressure: src side val/rdy, manager side val/rdy; val holds its payload until rdy.
// Ports: src_padder_data_val/_data/_data_last/_data_bytes, padder_src_rdy,
//        padder_manager_data_val/_data/_data_last, manager_padder_rdy.
// Modports: slave = the padder, master = the environment around it.
interface sha256_padder_if;
    import sha256_pkg::*;

    logic                     src_padder_data_val;
    logic [SRC_IF_DATA_W-1:0] src_padder_data;
    logic                     src_padder_data_last;
    logic [2:0]               src_padder_data_bytes;
    logic                     padder_src_rdy;

    logic                     padder_manager_data_val;
    logic [SHA_IF_DATA_W-1:0] padder_manager_data;
    logic                     padder_manager_data_last;
    logic                     manager_padder_rdy;

    modport slave (
        input  src_padder_data_val, src_padder_data, src_padder_data_last,
               src_padder_data_bytes, manager_padder_rdy,
        output padder_src_rdy, padder_manager_data_val, padder_manager_data,
               padder_manager_data_last
    );

    modport master (
        output src_padder_data_val, src_padder_data, src_padder_data_last,
               src_padder_data_bytes, manager_padder_rdy,
        input  padder_src_rdy, padder_manager_data_val, padder_manager_data,
               padder_manager_data_last
    );

endinterface

// File: rtl/sha256_padder_pad_word_gen.sv
// Purpose: terminates the final message word: masks trailing bytes and inserts 0x80.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: word/bytes/last in; pad_word out, need_pad_word set when the last word is full.
module sha256_pad_word_gen
    import sha256_pkg::*;
(
    input  logic [SRC_IF_DATA_W-1:0] word,
    input  logic [2:0]               bytes,
    input  logic                     last,
    output logic [SRC_IF_DATA_W-1:0] pad_word,
    output logic                     need_pad_word
);

    always_comb begin
        pad_word      = word;
        need_pad_word = 1'b0;
        if (last) begin
            // bytes==0 means all 8 bytes are message: the marker goes in a following word.
            if (bytes == 3'd0) begin
                need_pad_word = 1'b1;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if (i == int'(bytes)) begin
                        pad_word[SRC_IF_DATA_W-1-8*i -: 8] = SHA256_PAD_BYTE;
                    end else if (i > int'(bytes)) begin
                        pad_word[SRC_IF_DATA_W-1-8*i -: 8] = 8'h00;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// Purpose: pads a byte-granular message (64-bit words) and emits 256-bit half-blocks, upper half first.
// Latency: one cycle from the word completing a half to half-block valid; one cycle per pad word.
// Backpressure: padder_src_rdy drops while padding/sending; half-block data/last held until manager rdy.
// Ports: clk, rst (async, active-high), bus (sha256_padder_if.slave),
//        padder_len_ovf (sticky count overflow, only with SHA256_PADDER_LEN_CHK_EN defined).
module sha256_padder
    import sha256_pkg::*;
(
    input  logic clk,
    input  logic rst,
    sha256_padder_if.slave bus
`ifdef SHA256_PADDER_LEN_CHK_EN
    ,
    output logic padder_len_ovf
`endif
);

    padder_state_e            state_q, state_d;
    logic [2:0]               widx_q, widx_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic [SHA_IF_DATA_W-1:0] buf_q, buf_d;
    logic                     pend80_q, pend80_d;   // 0x80 still owed (message ended word-aligned)
    logic                     msg_end_q, msg_end_d; // last source word already taken
    logic                     rdy_q, rdy_d;
    logic                     val_q, val_d;
    logic                     last_q, last_d;

    logic [SRC_IF_DATA_W-1:0] gen_word;
    logic                     gen_need_pad;
    logic                     src_acc;
    logic                     half_full;
    logic [3:0]               add4;
    logic [LEN_W-1:0]         cnt_add;
    logic                     wr_en;
    logic                     len_wr;
    logic [SRC_IF_DATA_W-1:0] wr_word;

    sha256_pad_word_gen u_pad_word_gen (
        .word          (bus.src_padder_data),
        .bytes         (bus.src_padder_data_bytes),
        .last          (bus.src_padder_data_last),
        .pad_word      (gen_word),
        .need_pad_word (gen_need_pad)
    );

    assign src_acc   = bus.src_padder_data_val && rdy_q;
    assign half_full = (widx_q[1:0] == 2'(SHA256_WORDS_PER_HALF - 1));
    assign add4      = (bus.src_padder_data_last && (bus.src_padder_data_bytes != 3'd0))
                       ? {1'b0, bus.src_padder_data_bytes} : 4'd8;
    assign cnt_add   = {{(LEN_W-4){1'b0}}, add4};

    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        pend80_d  = pend80_q;
        msg_end_d = msg_end_q;
        wr_en     = 1'b0;
        len_wr    = 1'b0;
        wr_word   = '0;

        case (state_q)
            IDLE, FILL: begin
                if (src_acc) begin
                    wr_en   = 1'b1;
                    wr_word = gen_word;
                    cnt_d   = cnt_q + cnt_add;
                    if (bus.src_padder_data_last) begin
                        msg_end_d = 1'b1;
                        pend80_d  = gen_need_pad;
                    end
                    if (half_full)                     state_d = SEND;
                    else if (bus.src_padder_data_last) state_d = PAD;
                    else                               state_d = FILL;
                end
            end
            PAD: begin
                wr_en = 1'b1;
                // The owed marker takes priority even at index 7; the length then moves to an extra block.
                if (pend80_q) begin
                    wr_word  = pad_marker_word();
                    pend80_d = 1'b0;
                end else if (widx_q == 3'(SHA256_LEN_WORD_IDX)) begin
                    wr_word = {cnt_q, 3'b000};
                    len_wr  = 1'b1;
                end
                if (half_full) state_d = SEND;
            end
            SEND: begin
                if (bus.manager_padder_rdy) begin
                    if (last_q) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        widx_d    = '0;
                        msg_end_d = 1'b0;
                        pend80_d  = 1'b0;
                    end else if (msg_end_q) begin
                        state_d = PAD;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_en) begin
            widx_d = widx_q + 3'd1;
            for (int i = 0; i < SHA256_WORDS_PER_HALF; i++) begin
                if (widx_q[1:0] == 2'(i)) begin
                    buf_d[SHA_IF_DATA_W-1-SRC_IF_DATA_W*i -: SRC_IF_DATA_W] = wr_word;
                end
            end
        end

        rdy_d  = (state_d == IDLE) || (state_d == FILL);
        val_d  = (state_d == SEND);
        last_d = (state_d == SEND) && ((state_q == SEND) ? last_q : len_wr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            widx_q    <= '0;
            cnt_q     <= '0;
            buf_q     <= '0;
            pend80_q  <= 1'b0;
            msg_end_q <= 1'b0;
            rdy_q     <= 1'b0;
            val_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            pend80_q  <= pend80_d;
            msg_end_q <= msg_end_d;
            rdy_q     <= rdy_d;
            val_q     <= val_d;
            last_q    <= last_d;
        end
    end

    assign bus.padder_src_rdy           = rdy_q;
    assign bus.padder_manager_data_val  = val_q;
    assign bus.padder_manager_data      = buf_q;
    assign bus.padder_manager_data_last = last_q;

`ifdef SHA256_PADDER_LEN_CHK_EN
    logic ovf_q, ovf_d;

    // ~cnt_add equals (2^LEN_W-1) - cnt_add, so this compare is exactly "sum exceeds the max".
    assign ovf_d = ovf_q | (src_acc && (cnt_q > ~cnt_add));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign padder_len_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
module tb_sha256_padder;
    import sha256_pkg::*;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [255:0] d;
        logic         l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha256_padder_if bus();
`ifdef SHA256_PADDER_LEN_CHK_EN
    logic padder_len_ovf;
`endif

    sha256_padder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SHA256_PADDER_LEN_CHK_EN
        ,
        .padder_len_ovf (padder_len_ovf)
`endif
    );

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   stall_req  = 0;
    int   stall_used = 0;
    bit   rnd_stall  = 0;

    // Manager side: decides rdy at each falling edge and scores the half taken at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            bus.manager_padder_rdy = 1'b0;
        end else if (bus.padder_manager_data_val) begin
            if (stall_used < stall_req) begin
                bus.manager_padder_rdy = 1'b0;
                stall_used++;
            end else if (rnd_stall && $urandom_range(0, 2) == 0) begin
                bus.manager_padder_rdy = 1'b0;
            end else begin
                bus.manager_padder_rdy = 1'b1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got half %h last %b, required no output",
                             bus.padder_manager_data, bus.padder_manager_data_last);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (bus.padder_manager_data !== e.d) begin
                        n_fail++;
                        $display("FAIL sb_data: got %h required %h", bus.padder_manager_data, e.d);
                    end
                    n_checks++;
                    if (bus.padder_manager_data_last !== e.l) begin
                        n_fail++;
                        $display("FAIL sb_last: got %b required %b", bus.padder_manager_data_last, e.l);
                    end
                end
            end
        end else begin
            bus.manager_padder_rdy = 1'b1;
        end
    end

    task automatic make_msg(input int n, output bq_t m);
        m.delete();
        for (int i = 0; i < n; i++) m.push_back(8'($urandom));
    endtask

    // Reference padding: byte-level FIPS 180-4, then cut into 32-byte halves.
    task automatic push_model(input bq_t m);
        bq_t         p;
        logic [63:0] bl;
        exp_t        e;
        int          nh;
        p = m;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bl = 64'(m.size()) * 64'd8;
        for (int j = 7; j >= 0; j--) p.push_back(bl[8*j +: 8]);
        nh = p.size() / 32;
        for (int h = 0; h < nh; h++) begin
            e.d = '0;
            for (int j = 0; j < 32; j++) e.d = {e.d[247:0], p[h*32+j]};
            e.l = (h == nh - 1);
            exp_q.push_back(e);
        end
    endtask

    // Drives up to max_words words; bytes beyond the message are random to exercise masking.
    task automatic drive_msg(input bq_t m, input int max_words);
        int          n;
        int          nw;
        int          idx;
        int          cyc;
        logic [63:0] w;
        n  = m.size();
        nw = (n + 7) / 8;
        for (int k = 0; k < nw && k < max_words; k++) begin
            w = '0;
            for (int j = 0; j < 8; j++) begin
                idx = k * 8 + j;
                w = {w[55:0], (idx < n) ? m[idx] : 8'($urandom)};
            end
            bus.src_padder_data       = w;
            bus.src_padder_data_last  = (k == nw - 1);
            bus.src_padder_data_bytes = (k == nw - 1) ? 3'(n % 8) : 3'($urandom);
            bus.src_padder_data_val   = 1'b1;
            cyc = 0;
            while (!bus.padder_src_rdy && cyc < 400) begin
                @(negedge clk);
                cyc++;
            end
            if (!bus.padder_src_rdy) begin
                n_checks++;
                n_fail++;
                $display("FAIL src_rdy_timeout: rdy %b after %0d cycles, required 1", bus.padder_src_rdy, cyc);
                bus.src_padder_data_val = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.src_padder_data_val  = 1'b0;
        bus.src_padder_data_last = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d halves outstanding, required 0", name, exp_q.size());
        end
        n_checks++;
        if (bus.padder_manager_data_val !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_val: got %b required 0", name, bus.padder_manager_data_val);
        end
    endtask

    task automatic test_reset;
        bus.src_padder_data_val   = 1'b0;
        bus.src_padder_data       = '0;
        bus.src_padder_data_last  = 1'b0;
        bus.src_padder_data_bytes = '0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.padder_src_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_rdy: got %b required 0", bus.padder_src_rdy); end
        n_checks++;
        if (bus.padder_manager_data_val !== 1'b0) begin n_fail++; $display("FAIL rst_val: got %b required 0", bus.padder_manager_data_val); end
        n_checks++;
        if (bus.padder_manager_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h required 0", bus.padder_manager_data); end
        n_checks++;
        if (bus.padder_manager_data_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b required 0", bus.padder_manager_data_last); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.padder_src_rdy !== 1'b1) begin n_fail++; $display("FAIL idle_rdy: got %b required 1", bus.padder_src_rdy); end
        n_checks++;
        if (bus.padder_manager_data_val !== 1'b0) begin n_fail++; $display("FAIL idle_val: got %b required 0", bus.padder_manager_data_val); end
    endtask

    task automatic test_abc;
        bq_t  m;
        exp_t e;
        m = '{8'h61, 8'h62, 8'h63};
        e.d = {32'h6162_6380, 224'h0};
        e.l = 1'b0;
        exp_q.push_back(e);
        e.d = 256'h18;
        e.l = 1'b1;
        exp_q.push_back(e);
        drive_msg(m, 99);
        wait_drain("abc");
    endtask

    task automatic test_len_boundaries;
        bq_t m;
        int  lens[3] = '{55, 56, 64};
        foreach (lens[i]) begin
            make_msg(lens[i], m);
            push_model(m);
            drive_msg(m, 99);
            wait_drain($sformatf("len%0d", lens[i]));
        end
    endtask

    task automatic test_backpressure;
        bq_t          m;
        logic [255:0] hd;
        logic         hl;
        int           cyc;
        make_msg(20, m);
        push_model(m);
        stall_req += 5;
        fork
            drive_msg(m, 99);
            begin
                cyc = 0;
                while (!bus.padder_manager_data_val && cyc < 500) begin
                    @(negedge clk);
                    cyc++;
                end
                hd = bus.padder_manager_data;
                hl = bus.padder_manager_data_last;
                n_checks++;
                if (bus.padder_manager_data_val !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_val_timeout: val %b after %0d cycles, required 1", bus.padder_manager_data_val, cyc);
                end
                repeat (4) begin
                    @(negedge clk);
                    n_checks++;
                    if (bus.padder_manager_data_val !== 1'b1) begin n_fail++; $display("FAIL bp_val: got %b required 1", bus.padder_manager_data_val); end
                    n_checks++;
                    if (bus.padder_manager_data !== hd) begin n_fail++; $display("FAIL bp_data: got %h required %h", bus.padder_manager_data, hd); end
                    n_checks++;
                    if (bus.padder_manager_data_last !== hl) begin n_fail++; $display("FAIL bp_last: got %b required %b", bus.padder_manager_data_last, hl); end
                    n_checks++;
                    if (bus.padder_src_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_src_rdy: got %b required 0", bus.padder_src_rdy); end
                end
            end
        join
        wait_drain("bp");
    endtask

    task automatic test_reset_mid;
        bq_t m;
        make_msg(24, m);
        drive_msg(m, 2);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.padder_manager_data !== '0) begin n_fail++; $display("FAIL rmid_data: got %h required 0", bus.padder_manager_data); end
        n_checks++;
        if (bus.padder_src_rdy !== 1'b0) begin n_fail++; $display("FAIL rmid_rdy: got %b required 0", bus.padder_src_rdy); end
        n_checks++;
        if (bus.padder_manager_data_val !== 1'b0) begin n_fail++; $display("FAIL rmid_val: got %b required 0", bus.padder_manager_data_val); end
        n_checks++;
        if (bus.padder_manager_data_last !== 1'b0) begin n_fail++; $display("FAIL rmid_last: got %b required 0", bus.padder_manager_data_last); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_abc();
    endtask

    task automatic test_back_to_back;
        bq_t m;
        int  lens[14] = '{1, 7, 8, 9, 31, 32, 33, 54, 57, 63, 65, 119, 120, 128};
        rnd_stall = 1;
        foreach (lens[i]) begin
            make_msg(lens[i], m);
            push_model(m);
            drive_msg(m, 99);
        end
        wait_drain("b2b");
        rnd_stall = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_abc();
        test_len_boundaries();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
